// File: rtl/vending_fsm_if.sv
`default_nettype none
// ============================================================================
// vending_fsm_if : coin/selection/payout bundle (drink_out with VENDING_DRINK_OUT_EN)
// Rev 1.0
// ============================================================================
interface vending_fsm_if;
  logic [31:0] coin;
  logic [2:0]  drink_choose;
  logic        cancel;
  logic [31:0] change;
  logic [31:0] total_coin;
`ifdef VENDING_DRINK_OUT_EN
  logic [2:0]  drink_out;

  modport master (output coin, drink_choose, cancel, input change, total_coin, drink_out);
  modport slave  (input coin, drink_choose, cancel, output change, total_coin, drink_out);
`else
  modport master (output coin, drink_choose, cancel, input change, total_coin);
  modport slave  (input coin, drink_choose, cancel, output change, total_coin);
`endif
endinterface
`default_nettype wire

// File: rtl/vending_fsm.sv
`default_nettype none
// ============================================================================
// vending_fsm : credit accumulator / dispense / refund controller.
// Optional drink_out port enabled by macro VENDING_DRINK_OUT_EN.  Rev 1.0
// ============================================================================
module vending_fsm #(
  parameter logic [31:0] PRICE_TEA    = 32'd10,
  parameter logic [31:0] PRICE_COKE   = 32'd15,
  parameter logic [31:0] PRICE_COFFEE = 32'd20,
  parameter logic [31:0] PRICE_MILK   = 32'd25
) (
  input  wire logic         clk,
  input  wire logic         reset,
  vending_fsm_if.slave      bus
);

  typedef enum logic [2:0] {
    S_LOW    = 3'd0,
    S_TEA    = 3'd1,
    S_COKE   = 3'd2,
    S_COFFEE = 3'd3,
    S_MILK   = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_total, w_total_nxt;
  logic [31:0] r_change, w_change_nxt;
  logic [2:0]  r_drink_out, w_drink_out_nxt;

  logic [32:0] w_sum;
  logic        w_coin_ok;
  logic [31:0] w_credit;
  logic [31:0] w_refund;
  logic        w_dispense;

  function automatic state_t state_of(input logic [31:0] credit);
    if (credit >= PRICE_MILK)        state_of = S_MILK;
    else if (credit >= PRICE_COFFEE) state_of = S_COFFEE;
    else if (credit >= PRICE_COKE)   state_of = S_COKE;
    else if (credit >= PRICE_TEA)    state_of = S_TEA;
    else                             state_of = S_LOW;
  endfunction

  function automatic logic [31:0] price_of(input logic [2:0] code);
    case (code)
      3'b001:  price_of = PRICE_TEA;
      3'b010:  price_of = PRICE_COKE;
      3'b011:  price_of = PRICE_COFFEE;
      3'b100:  price_of = PRICE_MILK;
      default: price_of = 32'd0;
    endcase
  endfunction

  // Drink codes 1..4 line up with state encodings S_TEA..S_MILK, so
  // affordability is a direct compare against the registered state.
  always_comb begin
    w_sum      = {1'b0, r_total} + {1'b0, bus.coin};
    w_coin_ok  = ((bus.coin == 32'd1) || (bus.coin == 32'd5) || (bus.coin == 32'd10))
                 && !w_sum[32];
    w_credit   = w_coin_ok ? bus.coin : 32'd0;
    w_refund   = w_coin_ok ? 32'd0 : bus.coin;
    w_dispense = (bus.drink_choose >= 3'b001) && (bus.drink_choose <= 3'b100)
                 && (r_state >= state_t'(bus.drink_choose));

    w_state_nxt     = S_LOW;
    w_total_nxt     = 32'd0;
    w_change_nxt    = 32'd0;
    w_drink_out_nxt = 3'b000;

    if (bus.cancel) begin
      w_change_nxt = r_total + w_credit + w_refund;
    end else if (w_dispense) begin
      w_change_nxt    = r_total - price_of(bus.drink_choose) + w_credit + w_refund;
      w_drink_out_nxt = bus.drink_choose;
    end else begin
      w_total_nxt  = w_sum[31:0] - w_refund;
      w_change_nxt = w_refund;
      w_state_nxt  = state_of(w_total_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_LOW;
      r_total     <= 32'd0;
      r_change    <= 32'd0;
      r_drink_out <= 3'b000;
    end else begin
      r_state     <= w_state_nxt;
      r_total     <= w_total_nxt;
      r_change    <= w_change_nxt;
      r_drink_out <= w_drink_out_nxt;
    end
  end

  assign bus.change     = r_change;
  assign bus.total_coin = r_total;
`ifdef VENDING_DRINK_OUT_EN
  assign bus.drink_out  = r_drink_out;
`else
  logic w_unused_drink;
  assign w_unused_drink = ^r_drink_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm.sv
`default_nettype none
// ============================================================================
// tb_vending_fsm : directed vectors against hand-computed credit/change values.
// Rev 1.0
// ============================================================================
module tb_vending_fsm;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  vending_fsm_if bus ();

  vending_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then check outputs 1 time unit after it.
  task automatic step(input logic [31:0] coin, input logic [2:0] drink, input logic cancel,
                      input logic [31:0] exp_total, input logic [31:0] exp_change,
                      input logic [2:0] exp_drink, input string tag);
    bus.coin         = coin;
    bus.drink_choose = drink;
    bus.cancel       = cancel;
    @(posedge clk);
    #1;
    chk({tag, ".total"}, bus.total_coin, exp_total);
    chk({tag, ".change"}, bus.change, exp_change);
`ifdef VENDING_DRINK_OUT_EN
    chk({tag, ".drink"}, {29'd0, bus.drink_out}, {29'd0, exp_drink});
`else
    if (exp_drink == 3'b111) $display("unused drink code");
`endif
  endtask

  initial begin
    bus.coin = 0; bus.drink_choose = 0; bus.cancel = 0;
    reset = 1'b0;
    #1;
    // 1. reset
    step(0, 0, 0, 0, 0, 0, "rst");
    reset = 1'b1;

    // 2. coins then cancel
    step(10, 0, 0, 10, 0, 0, "c10");
    step(1,  0, 0, 11, 0, 0, "c1");
    step(5,  0, 0, 16, 0, 0, "c5");
    step(0,  0, 1, 0, 16, 0, "cancel");
    step(0,  0, 0, 0, 0, 0, "idle1");

    // 3. underfunded milk ignored, then tea with change
    step(5,  0, 0, 5,  0, 0, "t3a");
    step(5,  0, 0, 10, 0, 0, "t3b");
    step(1,  0, 0, 11, 0, 0, "t3c");
    step(1,  0, 0, 12, 0, 0, "t3d");
    step(10, 0, 0, 22, 0, 0, "t3e");
    step(0,  4, 0, 22, 0, 0, "milk_low");
    step(10, 0, 0, 32, 0, 0, "t3f");
    step(0,  1, 0, 0, 22, 1, "tea");
    step(0,  0, 0, 0, 0, 0, "idle2");

    // 4. tea held, level-sensitive retrigger
    step(1,  1, 0, 1,  0, 0, "hold1");
    step(1,  1, 0, 2,  0, 0, "hold2");
    step(10, 1, 0, 12, 0, 0, "hold3");
    step(0,  1, 0, 0,  2, 1, "hold_disp");
    step(0,  1, 0, 0,  0, 0, "hold_empty");

    // 5. illegal coin returned, cancel beats selection
    step(5,  0, 0, 5,  0, 0, "t5a");
    step(7,  0, 0, 5,  7, 0, "bad7");
    step(0,  0, 0, 5,  0, 0, "t5b");
    step(10, 0, 0, 15, 0, 0, "t5c");
    step(5,  0, 0, 20, 0, 0, "t5d");
    step(0,  2, 1, 0, 20, 0, "cancel_coke");

    // exact-price coffee, invalid code, illegal coin folded into dispense
    step(10, 0, 0, 10, 0, 0, "x1");
    step(10, 0, 0, 20, 0, 0, "x2");
    step(0,  5, 0, 20, 0, 0, "code5");
    step(0,  3, 0, 0,  0, 3, "coffee_exact");
    step(10, 0, 0, 10, 0, 0, "x3");
    step(7,  1, 0, 0,  7, 1, "tea_bad7");
    step(10, 0, 0, 10, 0, 0, "x4");
    step(5,  1, 1, 0, 15, 0, "cancel_coin");

    // 6. reset mid-transaction, no refund
    step(10, 0, 0, 10, 0, 0, "t6a");
    step(5,  0, 0, 15, 0, 0, "t6b");
    reset = 1'b0;
    step(0,  0, 0, 0,  0, 0, "rst_mid");
    reset = 1'b1;
    step(0,  0, 0, 0,  0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
